// File: rtl/lgn_host_link.sv
// lgn_host_link: host-side initiator that streams in_vec out MSB byte first, then reassembles the response.
// Define LGN_HOST_TIMEOUT_EN to enable the receive watchdog (TIMEOUT_CYCLES).
module lgn_host_link #(
   parameter int INPUT_BITS     = 400,
   parameter int OUTPUT_BITS    = 50,
   parameter int BITS_PER_VALUE = 5,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [INPUT_BITS-1:0]  in_vec,
   output logic                   busy,
   output logic                   done,
   output logic [OUTPUT_BITS-1:0] out_vec,
   output logic                   err_format,
   output logic                   err_timeout,
   output logic [7:0]             tx_byte,
   output logic                   tx_dv,
   input  logic                   tx_active,
   input  logic                   tx_done,
   input  logic [7:0]             rx_byte,
   input  logic                   rx_dv
);
   localparam logic [15:0] TX_BYTES = 16'(INPUT_BITS / 8);
   localparam logic [15:0] RX_BYTES = 16'(OUTPUT_BITS / BITS_PER_VALUE);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [INPUT_BITS-1:0]  shift_q, shift_d;
   logic [OUTPUT_BITS-1:0] staging_q, staging_d, out_vec_d;
   logic [15:0]            tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0]             tx_byte_d;
   logic                   busy_d, done_d, tx_dv_d, err_format_d, err_timeout_d;
   logic                   rx_take, rx_bad, to_expire;
   logic [OUTPUT_BITS-1:0] rx_payload;

   // Each byte enters at the top and shifts down, so byte k lands at slot k after the last byte.
   assign rx_payload = OUTPUT_BITS'(rx_byte[BITS_PER_VALUE-1:0]) << (OUTPUT_BITS - BITS_PER_VALUE);
   assign rx_bad     = (rx_byte >> BITS_PER_VALUE) != 8'd0;

`ifdef LGN_HOST_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d  = '0;
      to_expire = 1'b0;
      if (state_q == RECV && !rx_dv) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) to_expire = 1'b1;
         else                                       to_cnt_d  = to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign to_expire = 1'b0;
`endif

   always_comb begin
      // NOTE: every target gets a default first, so no path through the case can infer a latch.
      state_d       = state_q;
      shift_d       = shift_q;
      staging_d     = staging_q;
      out_vec_d     = out_vec;
      tx_cnt_d      = tx_cnt_q;
      rx_cnt_d      = rx_cnt_q;
      tx_byte_d     = tx_byte;
      busy_d        = busy;
      done_d        = 1'b0;
      tx_dv_d       = 1'b0;
      err_format_d  = err_format;
      err_timeout_d = err_timeout;
      rx_take       = 1'b0;

      case (state_q)
         IDLE: if (start) begin
            shift_d       = in_vec;
            tx_cnt_d      = '0;
            rx_cnt_d      = '0;
            err_format_d  = 1'b0;
            err_timeout_d = 1'b0;
            busy_d        = 1'b1;
            state_d       = SEND;
         end
         SEND: if (!tx_active) begin
            tx_byte_d = shift_q[INPUT_BITS-1 -: 8];
            tx_dv_d   = 1'b1;
            state_d   = WAIT;
         end
         WAIT: if (tx_done) begin
            shift_d  = shift_q << 8;
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_d == TX_BYTES) begin
               state_d = RECV;
               rx_take = rx_dv;   // a byte arriving on the switch-over cycle is byte 0
            end else begin
               state_d = SEND;
            end
         end
         RECV:    rx_take = rx_dv;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (rx_take) begin
         staging_d    = (staging_q >> BITS_PER_VALUE) | rx_payload;
         rx_cnt_d     = rx_cnt_q + 16'd1;
         err_format_d = err_format | rx_bad;
         if (rx_cnt_d == RX_BYTES) begin
            if (!err_format_d) out_vec_d = staging_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
         end
      end

      if (to_expire) begin
         err_timeout_d = 1'b1;
         done_d        = 1'b1;
         busy_d        = 1'b0;
         state_d       = IDLE;
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         staging_q   <= '0;
         out_vec     <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         tx_byte     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         tx_dv       <= 1'b0;
         err_format  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         staging_q   <= staging_d;
         out_vec     <= out_vec_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_byte     <= tx_byte_d;
         busy        <= busy_d;
         done        <= done_d;
         tx_dv       <= tx_dv_d;
         err_format  <= err_format_d;
         err_timeout <= err_timeout_d;
      end
   end
endmodule

// File: tb/tb_lgn_host_link.sv
// tb_lgn_host_link: directed/randomized bench with a byte-level transmitter model and a vector reference model.
module tb_lgn_host_link;
   localparam int IB  = 400;
   localparam int OB  = 50;
   localparam int BPV = 5;
   localparam int TO  = 100;
   localparam int NTX = IB / 8;
   localparam int NRX = OB / BPV;

   logic          clk = 1'b0;
   logic          rst, start, tx_active, tx_done, rx_dv;
   logic [IB-1:0] in_vec;
   logic [7:0]    rx_byte;
   logic          busy, done, err_format, err_timeout, tx_dv;
   logic [OB-1:0] out_vec;
   logic [7:0]    tx_byte;

   int            checks = 0;
   int            errors = 0;
   logic [OB-1:0] exp_out;

   lgn_host_link #(
      .INPUT_BITS(IB), .OUTPUT_BITS(OB), .BITS_PER_VALUE(BPV), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy), .done(done),
      .out_vec(out_vec), .err_format(err_format), .err_timeout(err_timeout),
      .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_active(tx_active), .tx_done(tx_done),
      .rx_byte(rx_byte), .rx_dv(rx_dv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: byte i of the request is the i-th octet counted from the MSB end.
   function automatic logic [7:0] req_byte(input logic [IB-1:0] v, input int i);
      return v[IB-1-8*i -: 8];
   endfunction

   function automatic logic [OB-1:0] assemble(input logic [7:0] r[NRX]);
      logic [OB-1:0] o = '0;
      for (int i = 0; i < NRX; i++)
         for (int b = 0; b < BPV; b++) o[i*BPV + b] = r[i][b];
      return o;
   endfunction

   function automatic bit has_fmt_err(input logic [7:0] r[NRX]);
      bit e = 0;
      for (int i = 0; i < NRX; i++) if (r[i] >= 8'(1 << BPV)) e = 1;
      return e;
   endfunction

   function automatic logic [IB-1:0] rand_vec();
      logic [IB-1:0] v;
      for (int i = 0; i < IB/8; i++) v[8*i +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic rand_rsp(output logic [7:0] r[NRX], input bit inject_err);
      for (int i = 0; i < NRX; i++) r[i] = 8'($urandom_range(0, (1 << BPV) - 1));
      if (inject_err) r[$urandom_range(0, NRX-1)] |= 8'($urandom_range(1, 7)) << BPV;
   endtask

   // Starts a transaction and plays the transmitter until all request bytes are acknowledged.
   task automatic send_phase(input logic [IB-1:0] v, input bit hold, input bit early,
                             input logic [7:0] first_rsp);
      int got = 0, lat = 0, hold_left = 0;
      bit pending = 0;
      in_vec = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      in_vec = ~v;
      check("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 5000 && !(got == NTX && !pending); cyc++) begin
         tx_done = 1'b0;
         rx_dv   = 1'b0;
         if (tx_dv === 1'b1) begin
            check("tx_dv_only_when_free", {pending, tx_active}, 0);
            check($sformatf("tx_byte_%0d", got), tx_byte, req_byte(v, got));
            got++;
            pending   = 1;
            lat       = $urandom_range(1, 4);
            tx_active = 1'b1;
         end else if (pending) begin
            check("tx_byte_stable", tx_byte, req_byte(v, got-1));
            lat--;
            if (lat == 0) begin
               tx_done = 1'b1;
               pending = 0;
               if (hold && got == 1) hold_left = 200;
               else                  tx_active = 1'b0;
               if (got == NTX && early) begin
                  rx_dv   = 1'b1;
                  rx_byte = first_rsp;
               end
            end else if (got < 10) begin
               rx_dv   = 1'($urandom_range(0, 1));
               rx_byte = 8'hFF;
            end
         end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) tx_active = 1'b0;
         end
         @(negedge clk);
      end
      tx_done = 1'b0;
      rx_dv   = 1'b0;
      check("tx_count", got, NTX);
   endtask

   task automatic recv_phase(input logic [7:0] r[NRX], input int first_idx, input int n_send);
      for (int i = first_idx; i < n_send; i++) begin
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            start = (i < NRX-1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("no_early_done", done, 0);
         end
         start   = 1'b0;
         rx_byte = r[i];
         rx_dv   = 1'b1;
         @(negedge clk);
         rx_dv   = 1'b0;
         rx_byte = 8'($urandom);
         if (i < NRX-1) check("no_early_done", done, 0);
      end
   endtask

   task automatic full_txn(input logic [IB-1:0] v, input logic [7:0] r[NRX], input bit hold, input bit early);
      send_phase(v, hold, early, r[0]);
      recv_phase(r, early ? 1 : 0, NRX);
      check("done_pulse", done, 1);
      check("busy_low_at_done", busy, 0);
      check("err_format", err_format, has_fmt_err(r));
      check("err_timeout_clear", err_timeout, 0);
      if (!has_fmt_err(r)) exp_out = assemble(r);
      check("out_vec", out_vec, exp_out);
      @(negedge clk);
      check("done_single_cycle", done, 0);
   endtask

   initial begin
      logic [IB-1:0] v;
      logic [7:0]    r[NRX];
      int            n;

      rst = 1'b1; start = 1'b0; in_vec = '0; tx_active = 1'b0; tx_done = 1'b0;
      rx_byte = '0; rx_dv = 1'b0; exp_out = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tx_dv", tx_dv, 0);
      check("rst_err_format", err_format, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_tx_byte", tx_byte, 0);
      check("rst_out_vec", out_vec, 0);
      rst = 1'b0;
      @(negedge clk);

      // Stray tx_done/rx_dv while idle must do nothing.
      tx_done = 1'b1; rx_dv = 1'b1; rx_byte = 8'hFF;
      @(negedge clk);
      tx_done = 1'b0; rx_dv = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_stray_busy", busy, 0);
      check("idle_stray_tx_dv", tx_dv, 0);
      check("idle_stray_err", err_format, 0);

      // Ordering and reassembly with the canonical vectors.
      v = {8'hA5, 384'h0, 8'h3C};
      for (int i = 0; i < NRX; i++) r[i] = 8'(i + 1);
      full_txn(v, r, 0, 0);
      check("out_lo_slot", out_vec[4:0], 1);
      check("out_hi_slot", out_vec[49:45], 10);

      // Format error on the third byte keeps the previous result.
      v = rand_vec();
      for (int i = 0; i < NRX; i++) r[i] = 8'($urandom_range(0, 31));
      r[2] = 8'h21;
      full_txn(v, r, 0, 0);

      // Back-pressure hold after the first byte.
      v = rand_vec();
      rand_rsp(r, 0);
      full_txn(v, r, 1, 0);

      // First response byte coincides with the final tx_done; payload max value included.
      v = rand_vec();
      rand_rsp(r, 0);
      r[NRX-1] = 8'h1F;
      full_txn(v, r, 0, 1);

      // Reset in the middle of receive, then a clean transaction.
      v = rand_vec();
      rand_rsp(r, 0);
      send_phase(v, 0, 0, r[0]);
      recv_phase(r, 0, 4);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_out_vec", out_vec, 0);
      rst = 1'b0;
      exp_out = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_no_stale_done", done, 0);
      end
      v = rand_vec();
      rand_rsp(r, 0);
      full_txn(v, r, 0, 0);

`ifdef LGN_HOST_TIMEOUT_EN
      // Watchdog: five bytes then silence.
      v = rand_vec();
      rand_rsp(r, 0);
      send_phase(v, 0, 0, r[0]);
      recv_phase(r, 0, 5);
      n = 1;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("timeout_latency", n, TO + 1);
      check("timeout_flag", err_timeout, 1);
      check("timeout_busy", busy, 0);
      check("timeout_out_vec", out_vec, exp_out);
      @(negedge clk);
      check("timeout_done_single", done, 0);
`endif

      // A few fully random transactions, some with format errors.
      for (int t = 0; t < 3; t++) begin
         v = rand_vec();
         rand_rsp(r, t == 1);
         full_txn(v, r, 0, 1'($urandom_range(0, 1)));
      end

      n = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lgn_host_link.md
# lgn_host_link

Host-side initiator for the logic-gate-network byte link. Takes a parallel input vector and sends it as `INPUT_BITS/8` bytes to a byte-stream transmitter (uart_tx style), most-significant byte first. It then collects `OUTPUT_BITS/BITS_PER_VALUE` response bytes from a byte-stream receiver (uart_rx style) and reassembles the network output vector. It sits opposite the network-side responder and lets an FPGA-resident test harness drive a remote logic network.

## Interface
- `INPUT_BITS`, 400, width of `in_vec`; must be a multiple of 8.
- `OUTPUT_BITS`, 50, width of `out_vec`; must be a multiple of `BITS_PER_VALUE`.
- `BITS_PER_VALUE`, 5, payload bits per response byte; range 1..8.
- `TIMEOUT_CYCLES`, 1000000, receive watchdog limit; used only with `LGN_HOST_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transaction; sampled only in IDLE.
- `in_vec` in INPUT_BITS: input vector; captured on accepted `start`.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle pulse at end of a transaction (success or error).
- `out_vec` out OUTPUT_BITS: last successfully received result.
- `err_format` out 1: sticky; a response byte had nonzero unused upper bits.
- `err_timeout` out 1: sticky; watchdog expired.
- `tx_byte` out 8: byte to transmitter.
- `tx_dv` out 1: one-cycle send strobe.
- `tx_active` in 1: transmitter busy.
- `tx_done` in 1: transmitter finished a byte (one-cycle pulse).
- `rx_byte` in 8: byte from receiver.
- `rx_dv` in 1: receiver byte valid (one-cycle pulse).

## Operation
- States: IDLE, SEND, WAIT, RECV, FINISH.
- IDLE:
  - On `start`=1, latch `in_vec` into the shift register.
  - Clear the tx count, rx count, `err_format` and `err_timeout`.
  - Go to SEND.
- SEND: when `tx_active`=0, drive `tx_byte` = shift register bits [INPUT_BITS-1 -: 8] and pulse `tx_dv`, then go to WAIT.
- WAIT:
  - On `tx_done`, shift the register left by 8 and increment the tx count.
  - If the count reaches `INPUT_BITS/8`, go to RECV; otherwise return to SEND.
- RECV:
  - Each `rx_dv` writes `rx_byte[BITS_PER_VALUE-1:0]` into staging bits [k*BITS_PER_VALUE +: BITS_PER_VALUE], where k is the rx count (0 first).
  - If `rx_byte[7:BITS_PER_VALUE]` ≠ 0, set `err_format`; the byte is still stored.
  - After `OUTPUT_BITS/BITS_PER_VALUE` bytes, go to FINISH.
- FINISH:
  - If `err_format`=0, copy staging to `out_vec`; otherwise `out_vec` keeps its old value.
  - Pulse `done` and return to IDLE.
- `rx_dv` outside RECV is ignored; the byte is dropped and nothing is flagged.
- `start` outside IDLE is ignored.
- `tx_done` outside WAIT is ignored.
- Counters are 16 bits wide. All index arithmetic is unsigned.

## Timing
- Reset values:
  - `busy`, `done`, `tx_dv`, `err_format`, `err_timeout` = 0.
  - `tx_byte` = 0.
  - `out_vec` = 0.
  - State = IDLE.
- Reset mid-transaction aborts immediately. No `done` is issued. A partially received result is discarded.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` pulses.
- First `tx_dv` is asserted no earlier than 1 cycle after accept, and only once `tx_active`=0.
- `tx_dv` is never asserted twice for the same byte. `tx_byte` is stable from `tx_dv` until `tx_done`.
- `done` pulses exactly 1 cycle after the last `rx_dv`. `out_vec` is updated in that same cycle.
- `rx_dv` coinciding with the WAIT→RECV transition cycle is accepted as byte 0.

## Configuration
- `LGN_HOST_TIMEOUT_EN` defined:
  - A counter runs in RECV and resets on each `rx_dv`.
  - If it reaches `TIMEOUT_CYCLES` without a byte, set `err_timeout`, pulse `done` and go to IDLE; `out_vec` is unchanged.
  - `rx_dv` in the expiry cycle wins: the byte is accepted and no timeout is raised.
- `LGN_HOST_TIMEOUT_EN` undefined: no counter; RECV waits indefinitely; `err_timeout` is tied to 0.

## Test plan
- Send ordering, default params, `in_vec` = {8'hA5, 384'h0, 8'h3C}: 50 `tx_dv` pulses; first `tx_byte`=A5, last=3C; each pulse only after the prior `tx_done`.
- Reassembly: respond with 10 bytes 8'h01..8'h0A → `done` 1 cycle after the 10th `rx_dv`; `out_vec[4:0]`=1, `out_vec[49:45]`=10; `err_format`=0.
- Format error: 3rd response byte = 8'h21 → `err_format`=1 and `done` pulses; `out_vec` keeps its previous value.
- Back-pressure: hold `tx_active`=1 for 200 cycles after the 1st byte → no `tx_dv` during the hold; sending resumes after release; byte order is intact.
- Reset mid-RECV after 4 bytes, then a full new transaction → no stale `done`; result uses only new bytes.
- With `LGN_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: stop after 5 response bytes → `err_timeout`=1 and `done` at the 100th idle cycle; `busy`=0 afterwards.
